// File: rtl/pc_seq_pkg.sv
// Shared opcode encodings for the program sequencer
// and the control-unit decoder.
package pc_seq_pkg;

  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BR   = 3'd2;
  localparam logic [2:0] OP_BREL = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;
  localparam logic [2:0] OP_RSV6 = 3'd6;
  localparam logic [2:0] OP_RSV7 = 3'd7;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the control unit
// and the program sequencer.
interface pc_sequencer_if #(
  parameter int ADDR_W  = 6,
  parameter int OFF_W   = 4,
  parameter int DEPTH_W = 3
);

  logic              stall;
  logic [2:0]        op;
  logic              cond;
  logic [ADDR_W-1:0] target;
  logic [OFF_W-1:0]  offset;
  logic              clr_err;
  logic [ADDR_W-1:0] pc;
  logic [DEPTH_W-1:0] depth;
  logic              stack_ovf;
  logic              stack_unf;
  logic              illegal_op;

  modport master (
    output stall, op, cond, target,
    output offset, clr_err,
    input  pc, depth, stack_ovf,
    input  stack_unf, illegal_op
  );

  modport slave (
    input  stall, op, cond, target,
    input  offset, clr_err,
    output pc, depth, stack_ovf,
    output stack_unf, illegal_op
  );

endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO; dout is the current top
// entry so a pop can use it on the same edge.
module return_stack #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    cnt_q;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign wr_idx  = cnt_q[AW-1:0];
  assign top_idx = wr_idx - AW'(1);
  assign dout    = mem[top_idx];
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;

  always_ff @(negedge clk) begin
    if (push && !full)
      mem[wr_idx] <= din;
  end

  always_ff @(negedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (push && !full)
      cnt_q <= cnt_q + CW'(1);
    else if (pop && !empty)
      cnt_q <= cnt_q - CW'(1);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program sequencer: next-PC mux,
// wrap arithmetic, return stack and error flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = 6,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  parameter int OFF_W       = 4
) (
  input logic clk,
  input logic rst,
  pc_sequencer_if.slave bus
);

  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0]       pc_q;
  logic [ADDR_W-1:0]       pc_d;
  logic [ADDR_W-1:0]       pc_inc;
  logic [ADDR_W-1:0]       pc_rel;
  logic [ADDR_W-1:0]       top;
  logic signed [OFF_W-1:0] off_s;
  logic [DW-1:0]           count;
  logic full, empty, push, pop;
  logic ovf_q, unf_q, ill_q;
  logic ovf_set, unf_set, ill_set;

  assign off_s  = bus.offset;
  assign pc_inc = pc_q + ADDR_W'(1);
  // signed cast sign-extends; sum wraps both ways
  assign pc_rel = pc_q + ADDR_W'(off_s);

  always_comb begin
    pc_d    = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    ill_set = 1'b0;
    unique case (bus.op)
      OP_NEXT: ;
      OP_JMP:  pc_d = bus.target;
      OP_BR: begin
        if (bus.cond) pc_d = bus.target;
      end
      OP_BREL: begin
        if (bus.cond) pc_d = pc_rel;
      end
      OP_CALL: begin
        pc_d    = bus.target;
        push    = !full;
        ovf_set = full;
      end
      OP_RET: begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          pc_d = top;
          pop  = 1'b1;
        end
      end
      default: ill_set = 1'b1;
    endcase
    if (bus.stall) begin
      pc_d    = pc_q;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      ill_set = 1'b0;
    end
  end

  return_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (top),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      pc_q  <= ADDR_W'(RESET_ADDR);
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
      unf_q <= unf_set | (unf_q & ~bus.clr_err);
      ill_q <= ill_set;
    end
  end

  assign bus.pc         = pc_q;
  assign bus.depth      = count;
  assign bus.stack_ovf  = ovf_q;
  assign bus.stack_unf  = unf_q;
  assign bus.illegal_op = ill_q;

endmodule
